// File: rtl/fir_mc.sv
// fir_mc: multi-channel, time-multiplexed N-tap FIR filter.
// There is one multiply-accumulate unit, shared by all channels, and each
// channel keeps its own delay line. All channels share one coefficient set,
// which can be written only while the block is idle.
// Build option FIR_SATURATE_EN: when defined, the shifted accumulator is
// clamped to the signed M-bit range. When undefined, the low M bits are kept
// (two's-complement wrap).
// The identity reset coefficient is 1<<SHIFT. It is positive only when
// CW >= SHIFT+2.
module fir_mc #(
  parameter int N     = 16,
  parameter int M     = 24,
  parameter int C     = 4,
  parameter int CW    = 16,
  parameter int SHIFT = 15,
  localparam int CHW  = (C > 1) ? $clog2(C) : 1,
  localparam int TAW  = $clog2(N)
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [M-1:0]   in_data,
  input  logic [CHW-1:0] in_ch,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           coef_we,
  input  logic [TAW-1:0] coef_addr,
  input  logic [CW-1:0]  coef_data,
  output logic           busy,
  output logic [M-1:0]   out_data,
  output logic [CHW-1:0] out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  // Accumulator wide enough for N full-scale products without overflow.
  localparam int AW = M + CW + TAW;

  localparam logic signed [AW-1:0] ACC_ONE  = AW'(1);
  localparam logic signed [AW-1:0] SAT_MAX  = (ACC_ONE <<< (M - 1)) - ACC_ONE;
  localparam logic signed [AW-1:0] SAT_MIN  = -(ACC_ONE <<< (M - 1));
  localparam logic [CW-1:0]        COEF_ID  = CW'(1) << SHIFT;
  localparam logic [TAW-1:0]       LAST_TAP = TAW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } state_t;

  state_t                 state_q;
  logic [CHW-1:0]         ch_q;
  logic [M-1:0]           sample_q;
  logic [TAW-1:0]         addr_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic [M-1:0]           out_data_q;
  logic [M-1:0]           res_d;
  logic [CHW-1:0]         out_ch_q;
  logic                   out_valid_q;

  logic [CW-1:0]          coef_q [N];
  logic [M-1:0]           line_q [C][N];

  logic signed [M+CW-1:0] prod;
  logic                   ch_ok;
  logic                   coef_ok;
`ifdef FIR_SATURATE_EN
  logic signed [AW-1:0]   shifted;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

  // Tags >= C are accepted but dropped, and so are writes to taps >= N.
  assign ch_ok   = ({1'b0, in_ch} < (CHW + 1)'(C));
  assign coef_ok = ({1'b0, coef_addr} < (TAW + 1)'(N));

  // Shared MAC datapath: the current product is added to the accumulator,
  // and the result is scaled and reduced so it can be captured on the last tap.
  always_comb begin
    prod  = $signed(line_q[ch_q][addr_q]) * $signed(coef_q[addr_q]);
    acc_d = acc_q + AW'(prod);
`ifdef FIR_SATURATE_EN
    shifted = acc_d >>> SHIFT;
    if (shifted > SAT_MAX) begin
      res_d = M'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      res_d = M'(SAT_MIN);
    end else begin
      res_d = M'(shifted);
    end
`else
    res_d = M'(acc_d >>> SHIFT);
`endif
  end

  // Coefficient bank. Writes are taken only in IDLE. A write on the same edge
  // as an input acceptance therefore lands before that sample's MAC pass.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int unsigned t = 0; t < N; t++) begin
        coef_q[t] <= (t == 0) ? COEF_ID : '0;
      end
    end else if (coef_we && (state_q == IDLE) && coef_ok) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Control FSM with registered outputs. It also owns the delay lines and
  // the accumulator.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      sample_q    <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned c = 0; c < C; c++) begin
        for (int unsigned t = 0; t < N; t++) begin
          line_q[c][t] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // The sample is held here and pushed in LOAD. This keeps the
          // delay-line write away from the input handshake.
          if (in_valid && ch_ok) begin
            ch_q     <= in_ch;
            sample_q <= in_data;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          line_q[ch_q][0] <= sample_q;
          for (int unsigned t = 1; t < N; t++) begin
            line_q[ch_q][t] <= line_q[ch_q][t-1];
          end
          acc_q   <= '0;
          addr_q  <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q  <= acc_d;
          addr_q <= addr_q + 1'b1;
          if (addr_q == LAST_TAP) begin
            out_data_q  <= res_d;
            out_ch_q    <= ch_q;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
